// File: rtl/rv32im_lsu_seq.sv
// rv32im_lsu_seq: sequential load/store unit between the execute stage and the
// data-memory port. It accepts one request at a time, issues one or two
// aligned memory beats with a grant / read-valid handshake, and returns a
// single response. A misaligned access that crosses a word boundary is either
// split into two beats or reported as a fault, depending on MISALIGN_SPLIT.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o execute-stage request handshake
//   lsu_opcode_i            NONE, LB, LBU, LH, LHU, LW, SB, SH, SW
//   addr_mem_i, val_memwr_i request byte address and right-justified store data
//   resp_valid_o            one-cycle response pulse
//   val_memrd_o             extended load result, held until the next response
//   misalign_fault_o        fault flag, qualified by resp_valid_o
//   mem_req_o, mem_we_o     memory request and write enable
//   addr_mem_o              word-aligned beat address
//   wr_mask_o, val_memwr_o  byte-lane write enables and lane-shifted store data
//   mem_gnt_i               memory accepted the current request
//   mem_rvalid_i            read data valid
//   val_memrd_i             read data
module rv32im_lsu_seq #(
  parameter int API_DATA_WIDTH   = 32,
  parameter int API_ADDR_WIDTH   = 32,
  parameter bit MISALIGN_SPLIT   = 1'b1,
  parameter int LSU_OPCODE_WIDTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [LSU_OPCODE_WIDTH-1:0] lsu_opcode_i,
  input  logic [API_ADDR_WIDTH-1:0]   addr_mem_i,
  input  logic [31:0]                 val_memwr_i,
  output logic                        resp_valid_o,
  output logic [31:0]                 val_memrd_o,
  output logic                        misalign_fault_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [API_ADDR_WIDTH-1:0]   addr_mem_o,
  output logic [API_DATA_WIDTH/8-1:0] wr_mask_o,
  output logic [API_DATA_WIDTH-1:0]   val_memwr_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [API_DATA_WIDTH-1:0]   val_memrd_i
);
  localparam int BYTES = API_DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int AW    = API_ADDR_WIDTH;
  localparam int DW    = API_DATA_WIDTH;
  localparam int DW2   = 2 * API_DATA_WIDTH;
  localparam int MW2   = 2 * BYTES;

  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LB  = LSU_OPCODE_WIDTH'(4'd1);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LBU = LSU_OPCODE_WIDTH'(4'd2);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LH  = LSU_OPCODE_WIDTH'(4'd3);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LHU = LSU_OPCODE_WIDTH'(4'd4);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_LW  = LSU_OPCODE_WIDTH'(4'd5);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_SB  = LSU_OPCODE_WIDTH'(4'd6);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_SH  = LSU_OPCODE_WIDTH'(4'd7);
  localparam logic [LSU_OPCODE_WIDTH-1:0] OP_SW  = LSU_OPCODE_WIDTH'(4'd8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Access size in bytes; 0 means no memory access (NONE or unknown opcode).
  function automatic logic [2:0] op_size(input logic [LSU_OPCODE_WIDTH-1:0] op);
    logic [2:0] sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = 3'd1;
      OP_LH, OP_LHU, OP_SH: sz = 3'd2;
      OP_LW, OP_SW:         sz = 3'd4;
      default:              sz = 3'd0;
    endcase
    return sz;
  endfunction

  function automatic logic op_is_store(input logic [LSU_OPCODE_WIDTH-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Pick bytes [off, off+size) out of the two-beat assembly and extend them.
  function automatic logic [31:0] load_extract(input logic [LSU_OPCODE_WIDTH-1:0] op,
                                               input logic [DW2-1:0] asm_v,
                                               input logic [OFFW-1:0] off);
    logic [31:0] w;
    logic [31:0] r;
    w = 32'(asm_v >> {off, 3'b000});
    case (op)
      OP_LB:   r = {{24{w[7]}}, w[7:0]};
      OP_LBU:  r = {24'd0, w[7:0]};
      OP_LH:   r = {{16{w[15]}}, w[15:0]};
      OP_LHU:  r = {16'd0, w[15:0]};
      OP_LW:   r = w;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  state_t                      state_r, state_s;
  logic                        beat_r, beat_s;
  logic                        last_r, last_s;
  logic [LSU_OPCODE_WIDTH-1:0] op_r, op_s;
  logic [OFFW-1:0]             off_r, off_s;
  logic [AW-1:0]               base_r, base_s;
  logic [MW2-1:0]              mask_full_r, mask_full_s;
  logic [DW2-1:0]              data_full_r, data_full_s;
  logic [DW2-1:0]              asm_r, asm_s;
  logic [31:0]                 rd_r, rd_s;
  logic                        fault_r, fault_s;
  logic                        resp_r;

  logic [2:0]                  size_in_s;
  logic [OFFW-1:0]             off_in_s;
  logic [OFFW:0]               end_in_s;
  logic                        cross_in_s;
  logic [3:0]                  lane_mask_in_s;
  logic [31:0]                 data_in_s;

  logic                        mem_req_r, mem_req_s;
  logic                        mem_we_r, mem_we_s;
  logic [AW-1:0]               addr_mem_r, addr_mem_s;
  logic [BYTES-1:0]            wr_mask_r, wr_mask_s;
  logic [DW-1:0]               val_memwr_r, val_memwr_s;

  // Decode the incoming request: size, word offset, boundary crossing, lanes.
  always_comb begin
    size_in_s  = op_size(lsu_opcode_i);
    off_in_s   = addr_mem_i[OFFW-1:0];
    end_in_s   = {1'b0, off_in_s} + (OFFW+1)'(size_in_s);
    cross_in_s = (end_in_s > (OFFW+1)'(BYTES));
    case (size_in_s)
      3'd1:    begin lane_mask_in_s = 4'b0001; data_in_s = {24'd0, val_memwr_i[7:0]};  end
      3'd2:    begin lane_mask_in_s = 4'b0011; data_in_s = {16'd0, val_memwr_i[15:0]}; end
      3'd4:    begin lane_mask_in_s = 4'b1111; data_in_s = val_memwr_i;                end
      default: begin lane_mask_in_s = 4'b0000; data_in_s = 32'd0;                      end
    endcase
  end

  // Next-state logic and the next value of every latched field.
  always_comb begin
    state_s     = state_r;
    beat_s      = beat_r;
    last_s      = last_r;
    op_s        = op_r;
    off_s       = off_r;
    base_s      = base_r;
    mask_full_s = mask_full_r;
    data_full_s = data_full_r;
    asm_s       = asm_r;
    rd_s        = rd_r;
    fault_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_s        = lsu_opcode_i;
          off_s       = off_in_s;
          base_s      = {addr_mem_i[AW-1:OFFW], {OFFW{1'b0}}};
          // Two-word-wide lane image: beat 0 takes the low half, beat 1 the high.
          mask_full_s = MW2'(lane_mask_in_s) << off_in_s;
          data_full_s = DW2'(data_in_s) << {off_in_s, 3'b000};
          asm_s       = {DW2{1'b0}};
          beat_s      = 1'b0;
          last_s      = cross_in_s;
          if (size_in_s == 3'd0) begin
            state_s = ST_RESP;
          end else if (cross_in_s && !MISALIGN_SPLIT) begin
            state_s = ST_RESP;
            fault_s = 1'b1;
            rd_s    = 32'd0;
          end else begin
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          if (!op_is_store(op_r)) begin
            state_s = ST_WAIT;
          end else if (beat_r == last_r) begin
            state_s = ST_RESP;
          end else begin
            beat_s  = 1'b1;
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          if (beat_r) begin
            asm_s[DW2-1:DW] = val_memrd_i;
          end else begin
            asm_s[DW-1:0] = val_memrd_i;
          end
          if (beat_r == last_r) begin
            state_s = ST_RESP;
            rd_s    = load_extract(op_r, asm_s, off_r);
          end else begin
            beat_s  = 1'b1;
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Memory-port values for the cycle that follows, so the port is registered.
  always_comb begin
    mem_req_s = (state_s == ST_REQ);
    if (mem_req_s) begin
      mem_we_s   = op_is_store(op_s);
      addr_mem_s = base_s + (beat_s ? AW'(BYTES) : {AW{1'b0}});
      if (op_is_store(op_s)) begin
        wr_mask_s   = beat_s ? mask_full_s[MW2-1:BYTES] : mask_full_s[BYTES-1:0];
        val_memwr_s = beat_s ? data_full_s[DW2-1:DW] : data_full_s[DW-1:0];
      end else begin
        wr_mask_s   = {BYTES{1'b0}};
        val_memwr_s = {DW{1'b0}};
      end
    end else begin
      mem_we_s    = 1'b0;
      addr_mem_s  = {AW{1'b0}};
      wr_mask_s   = {BYTES{1'b0}};
      val_memwr_s = {DW{1'b0}};
    end
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      beat_r      <= 1'b0;
      last_r      <= 1'b0;
      op_r        <= {LSU_OPCODE_WIDTH{1'b0}};
      off_r       <= {OFFW{1'b0}};
      base_r      <= {AW{1'b0}};
      mask_full_r <= {MW2{1'b0}};
      data_full_r <= {DW2{1'b0}};
      asm_r       <= {DW2{1'b0}};
      rd_r        <= 32'd0;
      fault_r     <= 1'b0;
      resp_r      <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      addr_mem_r  <= {AW{1'b0}};
      wr_mask_r   <= {BYTES{1'b0}};
      val_memwr_r <= {DW{1'b0}};
    end else begin
      state_r     <= state_s;
      beat_r      <= beat_s;
      last_r      <= last_s;
      op_r        <= op_s;
      off_r       <= off_s;
      base_r      <= base_s;
      mask_full_r <= mask_full_s;
      data_full_r <= data_full_s;
      asm_r       <= asm_s;
      rd_r        <= rd_s;
      fault_r     <= fault_s;
      resp_r      <= (state_s == ST_RESP);
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      addr_mem_r  <= addr_mem_s;
      wr_mask_r   <= wr_mask_s;
      val_memwr_r <= val_memwr_s;
    end
  end

  // Ready is held low while reset is asserted and rises as soon as it is released.
  assign req_ready_o      = (state_r == ST_IDLE) && !rst_i;
  assign resp_valid_o     = resp_r;
  assign val_memrd_o      = rd_r;
  assign misalign_fault_o = fault_r;
  assign mem_req_o        = mem_req_r;
  assign mem_we_o         = mem_we_r;
  assign addr_mem_o       = addr_mem_r;
  assign wr_mask_o        = wr_mask_r;
  assign val_memwr_o      = val_memwr_r;

endmodule

// File: tb/tb_rv32im_lsu_seq.sv
// tb_rv32im_lsu_seq: self-checking bench for rv32im_lsu_seq. Three instances
// (32-bit split, 64-bit fault, 64-bit split) share the stimulus; one is
// selected at a time. A byte-array memory model supplies read data, and the
// expected beats and load results are derived byte by byte from the access
// rules.
module tb_rv32im_lsu_seq;
  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;
  int          sel;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mem [0:4095];

  logic        r0_ready, r0_resp, r0_fault, r0_req, r0_we;
  logic [31:0] r0_rd, r0_addr, r0_wd;
  logic [3:0]  r0_mask;
  logic        r1_ready, r1_resp, r1_fault, r1_req, r1_we;
  logic [31:0] r1_rd, r1_addr;
  logic [63:0] r1_wd;
  logic [7:0]  r1_mask;
  logic        r2_ready, r2_resp, r2_fault, r2_req, r2_we;
  logic [31:0] r2_rd, r2_addr;
  logic [63:0] r2_wd;
  logic [7:0]  r2_mask;

  logic        o_ready, o_resp, o_fault, o_req, o_we;
  logic [31:0] o_rd, o_addr;
  logic [63:0] o_wd;
  logic [7:0]  o_mask;

  rv32im_lsu_seq #(.API_DATA_WIDTH(32), .API_ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b1)) u0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && (sel == 0)), .req_ready_o(r0_ready),
    .lsu_opcode_i(op), .addr_mem_i(addr), .val_memwr_i(wdata),
    .resp_valid_o(r0_resp), .val_memrd_o(r0_rd), .misalign_fault_o(r0_fault),
    .mem_req_o(r0_req), .mem_we_o(r0_we), .addr_mem_o(r0_addr), .wr_mask_o(r0_mask),
    .val_memwr_o(r0_wd), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .val_memrd_i(rdata[31:0]));

  rv32im_lsu_seq #(.API_DATA_WIDTH(64), .API_ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && (sel == 1)), .req_ready_o(r1_ready),
    .lsu_opcode_i(op), .addr_mem_i(addr), .val_memwr_i(wdata),
    .resp_valid_o(r1_resp), .val_memrd_o(r1_rd), .misalign_fault_o(r1_fault),
    .mem_req_o(r1_req), .mem_we_o(r1_we), .addr_mem_o(r1_addr), .wr_mask_o(r1_mask),
    .val_memwr_o(r1_wd), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .val_memrd_i(rdata));

  rv32im_lsu_seq #(.API_DATA_WIDTH(64), .API_ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b1)) u2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && (sel == 2)), .req_ready_o(r2_ready),
    .lsu_opcode_i(op), .addr_mem_i(addr), .val_memwr_i(wdata),
    .resp_valid_o(r2_resp), .val_memrd_o(r2_rd), .misalign_fault_o(r2_fault),
    .mem_req_o(r2_req), .mem_we_o(r2_we), .addr_mem_o(r2_addr), .wr_mask_o(r2_mask),
    .val_memwr_o(r2_wd), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .val_memrd_i(rdata));

  always_comb begin
    o_ready = r2_ready; o_resp = r2_resp; o_fault = r2_fault; o_req = r2_req; o_we = r2_we;
    o_rd = r2_rd; o_addr = r2_addr; o_wd = r2_wd; o_mask = r2_mask;
    case (sel)
      0: begin
        o_ready = r0_ready; o_resp = r0_resp; o_fault = r0_fault; o_req = r0_req; o_we = r0_we;
        o_rd = r0_rd; o_addr = r0_addr; o_wd = {32'd0, r0_wd}; o_mask = {4'd0, r0_mask};
      end
      1: begin
        o_ready = r1_ready; o_resp = r1_resp; o_fault = r1_fault; o_req = r1_req; o_we = r1_we;
        o_rd = r1_rd; o_addr = r1_addr; o_wd = r1_wd; o_mask = r1_mask;
      end
      default: begin end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [3:0] o);
    case (o)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic logic [63:0] word_at(input logic [31:0] a);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = mem[12'(a + 32'(j))];
    return r;
  endfunction

  // One complete transaction: reference beats and result, then handshake and checks.
  task automatic txn(input logic [3:0] t_op, input logic [31:0] t_a, input logic [31:0] t_d,
                     input int gdly, input int rdly, input string tag);
    int          w, sz, nb, ofs, b, lane;
    bit          st, ld, flt;
    logic [31:0] base, v, exp_rd;
    logic [31:0] eaddr [2];
    logic [7:0]  emask [2];
    logic [63:0] edata [2];
    w    = (sel == 0) ? 4 : 8;
    sz   = size_of(t_op);
    st   = (t_op == OP_SB) || (t_op == OP_SH) || (t_op == OP_SW);
    ld   = (sz != 0) && !st;
    base = t_a - (t_a % 32'(w));
    for (int k = 0; k < 2; k++) begin
      eaddr[k] = base + 32'(k * w);
      emask[k] = 8'd0;
      edata[k] = 64'd0;
    end
    nb = 1;
    v  = 32'd0;
    for (int i = 0; i < sz; i++) begin
      ofs  = int'(t_a - base) + i;
      b    = ofs / w;
      lane = ofs % w;
      if (b > 0) nb = 2;
      if (st) begin
        emask[b][lane]        = 1'b1;
        edata[b][8*lane +: 8] = t_d[8*i +: 8];
      end
      v[8*i +: 8] = mem[12'(t_a + 32'(i))];
    end
    flt = (nb == 2) && (sel == 1);
    case (t_op)
      OP_LB:   exp_rd = {{24{v[7]}}, v[7:0]};
      OP_LBU:  exp_rd = {24'd0, v[7:0]};
      OP_LH:   exp_rd = {{16{v[15]}}, v[15:0]};
      OP_LHU:  exp_rd = {16'd0, v[15:0]};
      default: exp_rd = v;
    endcase

    check(64'(o_ready), 64'd1, {tag, "_ready"});
    req_valid = 1'b1; op = t_op; addr = t_a; wdata = t_d;
    step();
    req_valid = 1'b0; op = OP_NONE;
    if (sz == 0 || flt) begin
      check(64'(o_resp), 64'd1, {tag, "_resp_early"});
      check(64'(o_fault), 64'(flt), {tag, "_fault"});
      check(64'(o_req), 64'd0, {tag, "_no_memreq"});
      if (flt) check(64'(o_rd), 64'd0, {tag, "_fault_rd"});
    end else begin
      for (int bt = 0; bt < nb; bt++) begin
        for (int k = 0; k <= gdly; k++) begin
          check(64'(o_req), 64'd1, {tag, "_req"});
          check(64'(o_we), 64'(st), {tag, "_we"});
          check(64'(o_addr), 64'(eaddr[bt]), {tag, "_addr"});
          check(64'(o_mask), 64'(emask[bt]), {tag, "_mask"});
          check(o_wd, edata[bt], {tag, "_wdata"});
          check(64'(o_resp), 64'd0, {tag, "_resp_in_req"});
          gnt = (k == gdly);
          step();
          gnt = 1'b0;
        end
        if (ld) begin
          for (int k = 0; k <= rdly; k++) begin
            check(64'(o_req), 64'd0, {tag, "_req_in_wait"});
            check(64'(o_resp), 64'd0, {tag, "_resp_in_wait"});
            if (k == rdly) begin
              rvalid = 1'b1;
              rdata  = word_at(eaddr[bt]);
            end
            step();
            rvalid = 1'b0;
          end
        end
      end
      check(64'(o_resp), 64'd1, {tag, "_resp"});
      check(64'(o_fault), 64'd0, {tag, "_nofault"});
      check(64'(o_req), 64'd0, {tag, "_req_in_resp"});
      if (ld) check(64'(o_rd), 64'(exp_rd), {tag, "_rd"});
    end
    if (st && !flt) begin
      for (int i = 0; i < sz; i++) mem[12'(t_a + 32'(i))] = t_d[8*i +: 8];
    end
    step();
    check(64'(o_resp), 64'd0, {tag, "_resp_one_cycle"});
    check(64'(o_ready), 64'd1, {tag, "_ready_after"});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; op = OP_NONE; addr = 32'd0; wdata = 32'd0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 64'd0; sel = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    step();
    step();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check(64'(o_ready), 64'd0, "rst_ready");
      check(64'(o_resp), 64'd0, "rst_resp");
      check(64'(o_req), 64'd0, "rst_memreq");
      check(64'(o_rd), 64'd0, "rst_rd");
      check(64'(o_fault), 64'd0, "rst_fault");
      check(64'(o_mask), 64'd0, "rst_mask");
      check(64'(o_addr), 64'd0, "rst_addr");
      check(o_wd, 64'd0, "rst_wdata");
    end
    sel = 0;
    #1;
    rst = 1'b0;
    step();
    check(64'(o_ready), 64'd1, "ready_after_reset");

    // Aligned LW, grant in first REQ cycle, rvalid one cycle later.
    mem[12'h100] = 8'hEF; mem[12'h101] = 8'hBE; mem[12'h102] = 8'hAD; mem[12'h103] = 8'hDE;
    txn(OP_LW, 32'h100, 32'd0, 0, 0, "lw_aligned");
    check(64'(o_rd), 64'hDEADBEEF, "lw_value");

    // Byte and halfword extension from word 0x80FF7F01.
    mem[12'h200] = 8'h01; mem[12'h201] = 8'h7F; mem[12'h202] = 8'hFF; mem[12'h203] = 8'h80;
    txn(OP_LB, 32'h203, 32'd0, 0, 1, "lb_off3");
    check(64'(o_rd), 64'hFFFFFF80, "lb_off3_value");
    txn(OP_LBU, 32'h201, 32'd0, 1, 0, "lbu_off1");
    check(64'(o_rd), 64'h0000007F, "lbu_off1_value");
    txn(OP_LH, 32'h202, 32'd0, 0, 0, "lh_off2");
    check(64'(o_rd), 64'hFFFF80FF, "lh_off2_value");
    txn(OP_LHU, 32'h202, 32'd0, 2, 2, "lhu_off2");
    check(64'(o_rd), 64'h000080FF, "lhu_off2_value");

    // Split SW across a word boundary, then read it back.
    txn(OP_SW, 32'h103, 32'hAABBCCDD, 0, 0, "sw_split");
    txn(OP_LW, 32'h103, 32'd0, 1, 1, "lw_split");
    check(64'(o_rd), 64'hAABBCCDD, "lw_split_value");

    // Spurious rvalid and grant in IDLE, then a NONE request.
    rvalid = 1'b1; gnt = 1'b1;
    step();
    rvalid = 1'b0; gnt = 1'b0;
    check(64'(o_resp), 64'd0, "spurious_rvalid_resp");
    check(64'(o_req), 64'd0, "spurious_rvalid_req");
    step();
    check(64'(o_resp), 64'd0, "spurious_rvalid_resp2");
    txn(OP_NONE, 32'h40, 32'd0, 0, 0, "none");

    // SH with grant stall; reset in the third stall cycle aborts it.
    req_valid = 1'b1; op = OP_SH; addr = 32'h2; wdata = 32'h00001234;
    step();
    req_valid = 1'b0; op = OP_NONE;
    for (int k = 0; k < 3; k++) begin
      check(64'(o_req), 64'd1, "stall_req");
      check(64'(o_addr), 64'h0, "stall_addr");
      check(64'(o_mask), 64'b1100, "stall_mask");
      check(o_wd, 64'h12340000, "stall_wdata");
      if (k == 2) rst = 1'b1;
      step();
    end
    check(64'(o_req), 64'd0, "abort_req");
    check(64'(o_resp), 64'd0, "abort_resp");
    check(64'(o_ready), 64'd0, "abort_ready_in_reset");
    rst = 1'b0;
    step();
    check(64'(o_ready), 64'd1, "abort_ready_after");
    check(64'(o_resp), 64'd0, "abort_no_resp");
    rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    check(64'(o_resp), 64'd0, "stale_rvalid_resp");
    step();
    check(64'(o_resp), 64'd0, "stale_rvalid_resp2");
    check(64'(o_req), 64'd0, "stale_rvalid_req");

    // 64-bit, no split: misaligned LH faults without a memory access.
    sel = 1;
    #1;
    txn(OP_LH, 32'h7, 32'd0, 0, 0, "lh_fault64");

    // 64-bit with split: bytes 0x34 at 0x7 and 0x92 at 0x8.
    sel = 2;
    #1;
    mem[12'h007] = 8'h34; mem[12'h008] = 8'h92;
    txn(OP_LH, 32'h7, 32'd0, 1, 1, "lh_split64");
    check(64'(o_rd), 64'hFFFF9234, "lh_split64_value");

    // Random traffic on every configuration.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      for (int n = 0; n < 40; n++) begin
        txn(4'($urandom_range(8)), 32'($urandom_range(4095)), $urandom,
            int'($urandom_range(2)), int'($urandom_range(2)), "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
